// File: rtl/dm9312_scan_if.sv
// Bundle between the DM9312 scan controller and its surroundings: the
// frame request/result side toward game logic and the select/strobe/Y side
// toward the DM9312 8:1 data selector.
interface dm9312_scan_if;
   logic       start;
   logic       continuous;
   logic [7:0] mask;
   logic       y;
   logic       sel_a;
   logic       sel_b;
   logic       sel_c;
   logic       g_n;
   logic       busy;
   logic [7:0] frame;
   logic       frame_valid;

   modport master (
      input  start, continuous, mask, y,
      output sel_a, sel_b, sel_c, g_n, busy, frame, frame_valid
   );

   modport slave (
      output start, continuous, mask, y,
      input  sel_a, sel_b, sel_c, g_n, busy, frame, frame_valid
   );
endinterface

// File: rtl/dm9312_scan_ctrl.sv
// Scan sequencer for a DM9312 8:1 data selector. Walks the enabled slots in
// ascending order, settling the select lines with the strobe high, then
// strobing low and sampling Y on the last strobe cycle. The sampled bits are
// published as one byte with a single-cycle valid pulse.
module dm9312_scan_ctrl #(
   parameter int SETTLE_CYC = 1,
   parameter int DWELL_CYC  = 2
) (
   input  logic          clk,
   input  logic          reset,
   dm9312_scan_if.master bus
);

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);
   localparam logic [3:0] DWELL_LAST  = 4'(DWELL_CYC - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      STROBE = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t     state_q;
   logic [3:0] cnt_q;
   logic [2:0] slot_q;
   logic [7:0] mask_q;
   logic [7:0] shadow_q;
   logic [7:0] frame_q;
   logic       frame_valid_q;
   logic       busy_q;
   logic       g_n_q;

   logic [7:0] shadow_d;
   logic [7:0] upper_mask;
   logic [2:0] next_slot;
   logic       launch;

   // Index of the lowest set bit; 0 when no bit is set.
   function automatic logic [2:0] lowest_set(input logic [7:0] m);
      logic [2:0] r;
      r = '0;
      for (int i = 7; i >= 0; i--) begin
         if (m[i]) r = 3'(i);
      end
      return r;
   endfunction

   // Bits of m strictly above position s.
   function automatic logic [7:0] bits_above(input logic [7:0] m, input logic [2:0] s);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) begin
         r[i] = m[i] && (i > int'(s));
      end
      return r;
   endfunction

   // Shadow byte with the current slot's Y folded in, plus the next enabled slot.
   always_comb begin
      shadow_d         = shadow_q;
      shadow_d[slot_q] = bus.y;
      upper_mask       = bits_above(mask_q, slot_q);
      next_slot        = lowest_set(upper_mask);
   end

   // A frame begins from IDLE on start or continuous, and back-to-back after DONE
   // only in continuous mode; start is ignored everywhere else.
   assign launch = ((state_q == IDLE) && (bus.start || bus.continuous)) ||
                   ((state_q == DONE) && bus.continuous);

   // Scan FSM with registered strobe, select, busy and frame outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         slot_q        <= '0;
         mask_q        <= '0;
         shadow_q      <= '0;
         frame_q       <= '0;
         frame_valid_q <= 1'b0;
         busy_q        <= 1'b0;
         g_n_q         <= 1'b1;
      end else begin
         frame_valid_q <= 1'b0;
         unique case (state_q)
            IDLE, DONE: begin
               g_n_q <= 1'b1;
               if (launch) begin
                  mask_q   <= bus.mask;
                  shadow_q <= '0;
                  cnt_q    <= '0;
                  busy_q   <= 1'b1;
                  if (bus.mask != 8'h00) begin
                     slot_q  <= lowest_set(bus.mask);
                     state_q <= SETTLE;
                  end else begin
                     // Empty mask: publish an all-zero frame without strobing.
                     frame_q       <= '0;
                     frame_valid_q <= 1'b1;
                     state_q       <= DONE;
                  end
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            SETTLE: begin
               if (cnt_q == SETTLE_LAST) begin
                  cnt_q   <= '0;
                  g_n_q   <= 1'b0;
                  state_q <= STROBE;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            STROBE: begin
               if (cnt_q == DWELL_LAST) begin
                  cnt_q    <= '0;
                  g_n_q    <= 1'b1;
                  shadow_q <= shadow_d;
                  if (upper_mask != 8'h00) begin
                     // Select only moves here, with the strobe going high.
                     slot_q  <= next_slot;
                     state_q <= SETTLE;
                  end else begin
                     frame_q       <= shadow_d;
                     frame_valid_q <= 1'b1;
                     state_q       <= DONE;
                  end
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.sel_a       = slot_q[0];
   assign bus.sel_b       = slot_q[1];
   assign bus.sel_c       = slot_q[2];
   assign bus.g_n         = g_n_q;
   assign bus.busy        = busy_q;
   assign bus.frame       = frame_q;
   assign bus.frame_valid = frame_valid_q;

endmodule

// File: tb/tb_dm9312_scan_ctrl.sv
// Bench for dm9312_scan_ctrl: a DM9312 model (Y = D[sel] while strobed, 0
// otherwise) sits behind the controller; each frame is predicted from the
// data pattern, the mask latched at start and the slot timing arithmetic.
module tb_dm9312_scan_ctrl;

   localparam int S    = 1;
   localparam int D    = 2;
   localparam int SLOT = S + D;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] pat;
   int         cyc = 0;
   int         total = 0;
   int         bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dm9312_scan_if bus();

   dm9312_scan_ctrl #(.SETTLE_CYC(S), .DWELL_CYC(D)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // DM9312 behaviour: strobe high forces Y low.
   assign bus.y = bus.g_n ? 1'b0 : pat[{bus.sel_c, bus.sel_b, bus.sel_a}];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Observation of the strobe/select side and of published frames.
   int         glow;
   int         order_err;
   int         sel_err;
   logic [7:0] visited;
   logic [2:0] last_slot;
   logic       first_fall;
   logic       prev_g_n = 1'b1;
   logic [2:0] prev_sel = 3'd0;
   int         fv_cyc[$];
   logic [7:0] fv_frm[$];

   always @(negedge clk) begin
      logic [2:0] s;
      s = {bus.sel_c, bus.sel_b, bus.sel_a};
      if (bus.g_n === 1'b0) begin
         glow++;
         visited[s] = 1'b1;
         if (prev_g_n) begin
            if (!first_fall && s <= last_slot) order_err++;
            last_slot  = s;
            first_fall = 1'b0;
         end else if (s != prev_sel) begin
            sel_err++;
         end
      end
      if (bus.frame_valid === 1'b1) begin
         fv_cyc.push_back(cyc);
         fv_frm.push_back(bus.frame);
         first_fall = 1'b1;
      end
      prev_g_n = bus.g_n;
      prev_sel = s;
   end

   task automatic clear_mon();
      glow       = 0;
      order_err  = 0;
      sel_err    = 0;
      visited    = 8'h00;
      last_slot  = 3'd0;
      first_fall = 1'b1;
      fv_cyc.delete();
      fv_frm.delete();
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_fv(input int want, input int budget);
      int w;
      w = 0;
      while (fv_cyc.size() < want && w < budget) begin
         tick();
         w++;
      end
   endtask

   // One start-triggered frame; optional noise pulses start and scrambles mask while busy.
   task automatic run_frame(input logic [7:0] m, input logic [7:0] p, input bit noise, input string tag);
      int n;
      int t0;
      int w;
      tick();
      clear_mon();
      pat       = p;
      bus.mask  = m;
      bus.start = 1'b1;
      t0        = cyc;
      n         = $countones(m);
      tick();
      bus.start = 1'b0;
      w = 0;
      while (fv_cyc.size() == 0 && w < 300) begin
         if (noise && bus.busy) begin
            bus.start = 1'($urandom_range(0, 1));
            bus.mask  = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
         end
         tick();
         w++;
      end
      bus.start = 1'b0;
      repeat (6) tick();
      chk($sformatf("%s.pulses", tag), 32'(fv_cyc.size()), 32'd1);
      if (fv_cyc.size() > 0) begin
         chk($sformatf("%s.fv_cycle", tag), 32'(fv_cyc[0] - t0), 32'(1 + n * SLOT));
         chk($sformatf("%s.frame", tag), 32'(fv_frm[0]), 32'(p & m));
      end
      chk($sformatf("%s.frame_hold", tag), 32'(bus.frame), 32'(p & m));
      chk($sformatf("%s.g_n_low", tag), 32'(glow), 32'(n * D));
      chk($sformatf("%s.visited", tag), 32'(visited), 32'(m));
      chk($sformatf("%s.order", tag), 32'(order_err), 32'd0);
      chk($sformatf("%s.sel_stable", tag), 32'(sel_err), 32'd0);
      chk($sformatf("%s.idle", tag), 32'(bus.busy), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int quiet_err;
      int t0;
      reset          = 1'b1;
      bus.start      = 1'b0;
      bus.continuous = 1'b0;
      bus.mask       = 8'h00;
      pat            = 8'h00;
      clear_mon();
      repeat (3) tick();
      reset = 1'b0;

      // Reset state and quiet idle.
      chk("rst.sel", 32'({bus.sel_c, bus.sel_b, bus.sel_a}), 32'd0);
      chk("rst.g_n", 32'(bus.g_n), 32'd1);
      chk("rst.busy", 32'(bus.busy), 32'd0);
      chk("rst.frame", 32'(bus.frame), 32'h00);
      chk("rst.fv", 32'(bus.frame_valid), 32'd0);
      quiet_err = 0;
      repeat (20) begin
         tick();
         if ({bus.sel_c, bus.sel_b, bus.sel_a} != 3'd0 || bus.g_n !== 1'b1 ||
             bus.frame != 8'h00 || bus.frame_valid !== 1'b0 || bus.busy !== 1'b0)
            quiet_err++;
      end
      chk("idle.quiet", 32'(quiet_err), 32'd0);

      // Directed frames.
      run_frame(8'hFF, 8'hA5, 1'b0, "full");
      run_frame(8'b0100_1001, 8'hFF, 1'b1, "masked");
      run_frame(8'hFF, 8'h5A, 1'b1, "busy_start");
      run_frame(8'h80, 8'h80, 1'b1, "slot7");

      // Randomized frames.
      for (int k = 0; k < 10; k++) begin
         run_frame(8'($urandom), 8'($urandom), 1'b1, $sformatf("rnd%0d", k));
      end

      // Empty mask leaves frame at 00, which the following reset test relies on.
      run_frame(8'h00, 8'hFF, 1'b1, "mask0");

      // Reset in the middle of a scan.
      tick();
      clear_mon();
      pat       = 8'hA5;
      bus.mask  = 8'hFF;
      bus.start = 1'b1;
      t0        = cyc;
      tick();
      bus.start = 1'b0;
      while (cyc < t0 + 12) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("midrst.g_n", 32'(bus.g_n), 32'd1);
      chk("midrst.sel", 32'({bus.sel_c, bus.sel_b, bus.sel_a}), 32'd0);
      chk("midrst.busy", 32'(bus.busy), 32'd0);
      chk("midrst.frame", 32'(bus.frame), 32'h00);
      repeat (40) tick();
      chk("midrst.no_pulse", 32'(fv_cyc.size()), 32'd0);
      chk("midrst.g_n_after", 32'(bus.g_n), 32'd1);

      // Continuous mode with the pattern toggling between frames.
      tick();
      clear_mon();
      pat            = 8'h0F;
      bus.mask       = 8'hFF;
      bus.continuous = 1'b1;
      t0             = cyc;
      for (int k = 0; k < 3; k++) begin
         wait_fv(k + 1, 200);
         chk($sformatf("cont%0d.seen", k), 32'(fv_cyc.size() > k), 32'd1);
         if (fv_cyc.size() > k) begin
            chk($sformatf("cont%0d.cycle", k), 32'(fv_cyc[k] - t0), 32'((k + 1) * (8 * SLOT + 1)));
            chk($sformatf("cont%0d.frame", k), 32'(fv_frm[k]), (k % 2 == 0) ? 32'h0F : 32'hF0);
         end
         pat = ~pat;
      end
      repeat (10) tick();
      bus.continuous = 1'b0;
      wait_fv(4, 200);
      chk("cont3.seen", 32'(fv_cyc.size()), 32'd4);
      if (fv_cyc.size() > 3) begin
         chk("cont3.cycle", 32'(fv_cyc[3] - t0), 32'(4 * (8 * SLOT + 1)));
         chk("cont3.frame", 32'(fv_frm[3]), 32'hF0);
      end
      repeat (40) tick();
      chk("cont.stopped", 32'(fv_cyc.size()), 32'd4);
      chk("cont.idle", 32'(bus.busy), 32'd0);
      chk("cont.g_n_low", 32'(glow), 32'(4 * 8 * D));
      chk("cont.sel_stable", 32'(sel_err), 32'd0);
      chk("cont.order", 32'(order_err), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
